// File: rtl/attention_output_stage_if.sv
// Job handshake, job parameters and the two-SRAM read / one-SRAM write bus
// for attention_output_stage. slave = the block, master = the job issuer
// plus the SRAM models.
interface attention_output_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
);
  logic              start_valid;
  logic              start_ready;
  logic [DIM_W-1:0]  seq_len;
  logic [DIM_W-1:0]  d_model;
  logic [ADDR_W-1:0] s_base;
  logic [ADDR_W-1:0] v_base;
  logic [ADDR_W-1:0] z_base;
  logic [4:0]        score_shift;
  logic [ADDR_W-1:0] dut__tb__sram_result_read_address;
  logic [DATA_W-1:0] tb__dut__sram_result_read_data;
  logic [ADDR_W-1:0] dut__tb__sram_scratchpad_read_address;
  logic [DATA_W-1:0] tb__dut__sram_scratchpad_read_data;
  logic              dut__tb__sram_result_write_enable;
  logic [ADDR_W-1:0] dut__tb__sram_result_write_address;
  logic [DATA_W-1:0] dut__tb__sram_result_write_data;
  logic              done;

  modport slave (
    input  start_valid, seq_len, d_model, s_base, v_base, z_base, score_shift,
           tb__dut__sram_result_read_data, tb__dut__sram_scratchpad_read_data,
    output start_ready, done,
           dut__tb__sram_result_read_address, dut__tb__sram_scratchpad_read_address,
           dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
           dut__tb__sram_result_write_data
  );

  modport master (
    output start_valid, seq_len, d_model, s_base, v_base, z_base, score_shift,
           tb__dut__sram_result_read_data, tb__dut__sram_scratchpad_read_data,
    input  start_ready, done,
           dut__tb__sram_result_read_address, dut__tb__sram_scratchpad_read_address,
           dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
           dut__tb__sram_result_write_data
  );
endinterface

// File: rtl/attention_output_stage.sv
// attention_output_stage: Z = S x V (N x N times N x D), one output element
// at a time, j innermost. Each element: N read cycles, one drain cycle for
// the last read's data, one write cycle.
// Optional macro ATTN_OUT_SCALE_EN: write data is the accumulator shifted
// right by the score_shift sampled at job accept.
module attention_output_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic clk,
  input  logic reset_n,
  attention_output_stage_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  n_r, d_r, i_r, j_r, k_r;
  logic [ADDR_W-1:0] s_addr, s_row, v_addr, v_col, v_base_r, z_addr;
  logic [DATA_W-1:0] acc, prod;
  logic              rd_vld, rd_first;
  logic              accept, last_k, last_j, last_i;

  assign accept = bus.start_valid && (state == IDLE);
  assign last_k = (k_r == n_r - DIM_W'(1));
  assign last_j = (j_r == d_r - DIM_W'(1));
  assign last_i = (i_r == n_r - DIM_W'(1));
  assign prod   = bus.tb__dut__sram_result_read_data * bus.tb__dut__sram_scratchpad_read_data;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an empty job goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)
               state_nxt = (bus.seq_len == '0 || bus.d_model == '0) ? DONE : ISSUE;
      ISSUE: if (last_k) state_nxt = DRAIN;
      DRAIN: state_nxt = WRITE;
      WRITE: state_nxt = (last_i && last_j) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ATTN_OUT_SCALE_EN
  logic [4:0] shift_r;

  // Shift amount is captured with the rest of the job
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    shift_r <= '0;
    else if (accept) shift_r <= bus.score_shift;
  end

  assign bus.dut__tb__sram_result_write_data = acc >> shift_r;
`else
  logic unused_shift;
  assign unused_shift = ^bus.score_shift;
  assign bus.dut__tb__sram_result_write_data = acc;
`endif

  // Read data lags its address by one cycle; the k=0 product loads the
  // accumulator so no clear cycle is needed between elements
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      acc      <= '0;
    end else begin
      rd_vld   <= (state == ISSUE);
      rd_first <= (k_r == '0);
      if (rd_vld) acc <= rd_first ? prod : acc + prod;
    end
  end

  // Counters and running addresses; addresses step incrementally so no
  // multipliers are needed, and wrap naturally at ADDR_W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_r <= '0; d_r <= '0; i_r <= '0; j_r <= '0; k_r <= '0;
      s_addr <= '0; s_row <= '0; v_addr <= '0; v_col <= '0;
      v_base_r <= '0; z_addr <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          n_r      <= bus.seq_len;
          d_r      <= bus.d_model;
          i_r      <= '0;
          j_r      <= '0;
          k_r      <= '0;
          s_addr   <= bus.s_base;
          s_row    <= bus.s_base;
          v_addr   <= bus.v_base;
          v_col    <= bus.v_base;
          v_base_r <= bus.v_base;
          z_addr   <= bus.z_base;
        end
        ISSUE: begin
          s_addr <= s_addr + ADDR_W'(1);
          v_addr <= v_addr + ADDR_W'(d_r);
          k_r    <= last_k ? '0 : k_r + DIM_W'(1);
        end
        WRITE: begin
          z_addr <= z_addr + ADDR_W'(1);
          if (last_j) begin
            // s_addr already sits at the start of the next S row
            j_r    <= '0;
            i_r    <= i_r + DIM_W'(1);
            s_row  <= s_addr;
            v_col  <= v_base_r;
            v_addr <= v_base_r;
          end else begin
            j_r    <= j_r + DIM_W'(1);
            s_addr <= s_row;
            v_col  <= v_col + ADDR_W'(1);
            v_addr <= v_col + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready                           = (state == IDLE);
  assign bus.done                                  = (state == DONE);
  assign bus.dut__tb__sram_result_write_enable     = (state == WRITE);
  assign bus.dut__tb__sram_result_write_address    = z_addr;
  assign bus.dut__tb__sram_result_read_address     = s_addr;
  assign bus.dut__tb__sram_scratchpad_read_address = v_addr;

endmodule
